// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl - load/store unit between execute and write-back.
//
// Takes one memory access at a time from the core (decoder Mem_wr / funct3 /
// ALU address). It issues that access as a single outstanding request to data
// memory. It then returns formatted load data, or a bare completion for stores.
//
// Build option:
//   LSU_ALIGN_CHECK_EN  When defined, misaligned halfs and words, illegal
//                       funct3 codes and unsigned stores complete immediately
//                       with done_err=1 and never reach memory. When undefined,
//                       the low address bits that do not fit the access size
//                       are ignored, and done_err reports only a response
//                       timeout.
//
// Parameter:
//   RSP_TIMEOUT  Maximum number of WAIT cycles without mem_rsp_valid before the
//                access completes with an error. A value of 0 disables the
//                timeout.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     core request handshake (ready only while idle)
//   req_wr, req_bits        1=store / 0=load, funct3 size+sign code
//   req_addr, req_wdata     byte address, store data
//   mem_req_*               request channel to data memory
//   mem_rsp_valid/rdata     memory response (sampled only in WAIT)
//   done_valid/rdata/err    one-cycle completion pulse with load data / error
//   dbg_state_o             current FSM state, for observation only
//
// Handshake rule (both request channels): a transfer happens on a rising edge
// where valid and ready are both high. Once valid is raised, it and its
// payload stay stable until that edge.
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int RSP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_bits,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [3:0]  mem_req_wmask,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic        done_valid,
  output logic [31:0] done_rdata,
  output logic        done_err,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // The counter only has to reach RSP_TIMEOUT-1. The timeout fires on the
  // WAIT cycle in which the count already equals that value.
  localparam int                CNT_W      = (RSP_TIMEOUT < 2) ? 1 : $clog2(RSP_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(RSP_TIMEOUT - 1);
  localparam bit                TIMEOUT_EN = (RSP_TIMEOUT != 0);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         bits_q;
  logic               wr_q;
  logic [1:0]         off_q;          // effective lane offset of the access
  logic               req_ready_q;
  logic               mem_req_valid_q;
  logic [31:0]        mem_req_addr_q;
  logic               mem_req_wen_q;
  logic [3:0]         mem_req_wmask_q;
  logic [31:0]        mem_req_wdata_q;
  logic               done_valid_q;
  logic [31:0]        done_rdata_q;
  logic               done_err_q;

  // ---------------------------------------------------------------------------
  // Request decode, evaluated on the incoming request while idle.
  // funct3[1:0] selects the size: 00 byte, 01 half, 1x word. Half accesses use
  // only address bit 1, and word accesses ignore both low bits. The store
  // replicates its data across lanes, so the byte strobes alone select the
  // bytes that memory writes.
  // ---------------------------------------------------------------------------
  logic [1:0]  off_d;
  logic [1:0]  eff_off_d;
  logic [3:0]  wmask_d;
  logic [31:0] wdata_d;
  logic        align_err_d;

  always_comb begin
    off_d     = req_addr[1:0];
    eff_off_d = 2'b00;
    wmask_d   = 4'b1111;
    wdata_d   = req_wdata;
    case (req_bits[1:0])
      2'b00: begin
        eff_off_d = off_d;
        wmask_d   = 4'b0001 << off_d;
        wdata_d   = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        eff_off_d = {off_d[1], 1'b0};
        wmask_d   = 4'b0011 << {off_d[1], 1'b0};
        wdata_d   = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase

    align_err_d = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    if (req_bits == 3'b011 || req_bits[2:1] == 2'b11) begin
      align_err_d = 1'b1;                       // 011 / 110 / 111
    end else if (req_wr && req_bits[2]) begin
      align_err_d = 1'b1;                       // sbu / shu do not exist
    end else if (req_bits[1:0] == 2'b01 && off_d[0]) begin
      align_err_d = 1'b1;
    end else if (req_bits[1:0] == 2'b10 && off_d != 2'b00) begin
      align_err_d = 1'b1;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Load formatting: bring the addressed lane down to bit 0, then sign- or
  // zero-extend. funct3[2] marks the unsigned variants.
  // ---------------------------------------------------------------------------
  logic [31:0] rsp_shift;
  logic [31:0] load_fmt;

  always_comb begin
    rsp_shift = mem_rsp_rdata >> {off_q, 3'b000};
    case (bits_q[1:0])
      2'b00:   load_fmt = bits_q[2] ? {24'b0, rsp_shift[7:0]}
                                    : {{24{rsp_shift[7]}}, rsp_shift[7:0]};
      2'b01:   load_fmt = bits_q[2] ? {16'b0, rsp_shift[15:0]}
                                    : {{16{rsp_shift[15]}}, rsp_shift[15:0]};
      default: load_fmt = mem_rsp_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM. Every output is a register. Reset therefore clears them all
  // at once, including a request that is in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      bits_q          <= 3'b000;
      wr_q            <= 1'b0;
      off_q           <= 2'b00;
      req_ready_q     <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= 32'h0;
      mem_req_wen_q   <= 1'b0;
      mem_req_wmask_q <= 4'h0;
      mem_req_wdata_q <= 32'h0;
      done_valid_q    <= 1'b0;
      done_rdata_q    <= 32'h0;
      done_err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            wr_q        <= req_wr;
            bits_q      <= req_bits;
            off_q       <= eff_off_d;
            if (align_err_d) begin
              state_q      <= S_DONE;
              done_valid_q <= 1'b1;
              done_err_q   <= 1'b1;
              done_rdata_q <= 32'h0;
            end else begin
              state_q         <= S_REQ;
              mem_req_valid_q <= 1'b1;
              mem_req_addr_q  <= {req_addr[31:2], 2'b00};
              mem_req_wen_q   <= req_wr;
              mem_req_wmask_q <= req_wr ? wmask_d : 4'h0;
              mem_req_wdata_q <= req_wr ? wdata_d : 32'h0;
            end
          end
        end

        S_REQ: begin
          if (mem_req_ready) begin
            state_q         <= S_WAIT;
            cnt_q           <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= 32'h0;
            mem_req_wen_q   <= 1'b0;
            mem_req_wmask_q <= 4'h0;
            mem_req_wdata_q <= 32'h0;
          end
        end

        S_WAIT: begin
          // A response that arrives on the last counted cycle still wins
          // over the timeout.
          if (mem_rsp_valid) begin
            state_q      <= S_DONE;
            cnt_q        <= '0;
            done_valid_q <= 1'b1;
            done_err_q   <= 1'b0;
            done_rdata_q <= wr_q ? 32'h0 : load_fmt;
          end else if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
            state_q      <= S_DONE;
            cnt_q        <= '0;
            done_valid_q <= 1'b1;
            done_err_q   <= 1'b1;
            done_rdata_q <= 32'h0;
          end else if (TIMEOUT_EN) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_DONE: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          done_valid_q <= 1'b0;
          done_err_q   <= 1'b0;
          done_rdata_q <= 32'h0;
        end

        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_wen   = mem_req_wen_q;
  assign mem_req_wmask = mem_req_wmask_q;
  assign mem_req_wdata = mem_req_wdata_q;
  assign done_valid    = done_valid_q;
  assign done_rdata    = done_rdata_q;
  assign done_err      = done_err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_ctrl - self-checking bench for lsu_mem_ctrl (RSP_TIMEOUT = 4).
// A table of directed accesses comes first, then hand-written reset and
// alignment sequences. Randomised accesses follow, checked against a
// behavioural model. Expected completions go through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

  localparam int TO = 4;

  // ---------------------------------------------------------------- signals
  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [2:0]  req_bits;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [3:0]  mem_req_wmask;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        done_valid;
  logic [31:0] done_rdata;
  logic        done_err;
  logic [1:0]  dbg_state;

  lsu_mem_ctrl #(.RSP_TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wr        (req_wr),
    .req_bits      (req_bits),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wmask (mem_req_wmask),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .done_valid    (done_valid),
    .done_rdata    (done_rdata),
    .done_err      (done_err),
    .dbg_state_o   (dbg_state)
  );

  // ---------------------------------------------------------- clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // -------------------------------------------------------------- scoreboard
  int          checks;
  int          errors;
  logic [32:0] exp_q[$];   // {done_err, done_rdata} for each accepted access

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------- reference model
  function automatic int m_eff_off(input logic [2:0] bits, input logic [31:0] addr);
    int off;
    off = int'(addr % 4);
    if (bits % 4 == 0) return off;
    if (bits % 4 == 1) return (off / 2) * 2;
    return 0;
  endfunction

  function automatic logic m_align_err(input logic wr, input logic [2:0] bits, input logic [31:0] addr);
`ifdef LSU_ALIGN_CHECK_EN
    int off;
    off = int'(addr % 4);
    if (bits == 3 || bits == 6 || bits == 7) return 1'b1;
    if (wr && (bits == 4 || bits == 5)) return 1'b1;
    if ((bits == 1 || bits == 5) && (off % 2 != 0)) return 1'b1;
    if (bits == 2 && off != 0) return 1'b1;
    return 1'b0;
`else
    return (wr && !wr);
`endif
  endfunction

  function automatic logic [3:0] m_wmask(input logic wr, input logic [2:0] bits, input logic [31:0] addr);
    int off;
    off = m_eff_off(bits, addr);
    if (!wr) return 4'h0;
    if (bits % 4 == 0) return 4'(1 << off);
    if (bits % 4 == 1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] bits, input logic [31:0] wdata);
    if (bits % 4 == 0) return (wdata & 32'hFF) * 32'h01010101;
    if (bits % 4 == 1) return (wdata & 32'hFFFF) * 32'h00010001;
    return wdata;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] bits, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    logic [31:0] v;
    int off;
    off = m_eff_off(bits, addr);
    v = rdata >> (8 * off);
    if (bits % 4 == 0) begin
      v = v & 32'hFF;
      if (bits < 4 && v >= 128) v = v - 32'd256;
    end else if (bits % 4 == 1) begin
      v = v & 32'hFFFF;
      if (bits < 4 && v >= 32768) v = v - 32'h10000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // ----------------------------------------------------------- driver tasks
  // Called at cycle start (#1 after a rising edge) with the LSU idle. Memory
  // accepts the request after rdly stall cycles and answers sdly cycles into
  // WAIT. No answer arrives if sdly >= TO.
  task automatic run_access(input logic wr, input logic [2:0] bits, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int rdly, input int sdly,
                            input logic [3:0] e_wmask, input logic [31:0] e_wdata,
                            input logic [31:0] e_rdata, input logic e_err, input logic e_align);
    logic timed_out;
    int   n;
    timed_out = !e_align && (sdly >= TO);
    req_valid = 1'b1;
    req_wr    = wr;
    req_bits  = bits;
    req_addr  = addr;
    req_wdata = wdata;
    check("req_ready_idle", req_ready, 1);
    exp_q.push_back({e_err, e_rdata});
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    if (e_align) begin
      check("no_mem_req", mem_req_valid, 0);
    end else begin
      for (int i = 0; i <= rdly; i++) begin
        check("mem_req_valid", mem_req_valid, 1);
        check("mem_req_addr", mem_req_addr, {addr[31:2], 2'b00});
        check("mem_req_wen", mem_req_wen, wr);
        check("mem_req_wmask", mem_req_wmask, e_wmask);
        if (wr) check("mem_req_wdata", mem_req_wdata, e_wdata);
        check("req_ready_busy", req_ready, 0);
        mem_req_ready = (i == rdly);
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b0;
      n = timed_out ? TO : sdly + 1;
      for (int j = 0; j < n; j++) begin
        check("wait_no_done", done_valid, 0);
        check("wait_no_req", mem_req_valid, 0);
        mem_rsp_valid = (j == sdly);
        mem_rsp_rdata = (j == sdly) ? rdata : 32'($urandom);
        @(posedge clk); #1;
      end
      mem_rsp_valid = 1'b0;
    end
    // Completion cycle
    check("done_valid", done_valid, 1);
    if (exp_q.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      check("done_err_rdata", {done_err, done_rdata}, exp_q.pop_front());
    end
    if (timed_out) begin
      mem_rsp_valid = 1'b1;      // late response must be ignored
      mem_rsp_rdata = rdata;
    end
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    check("done_pulse_end", done_valid, 0);
    check("done_rdata_idle", done_rdata, 0);
    check("done_err_idle", done_err, 0);
    check("req_ready_back", req_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_mem_req_valid"}, mem_req_valid, 0);
    check({tag, "_mem_req_addr"}, mem_req_addr, 0);
    check({tag, "_mem_req_wen"}, mem_req_wen, 0);
    check({tag, "_mem_req_wmask"}, mem_req_wmask, 0);
    check({tag, "_mem_req_wdata"}, mem_req_wdata, 0);
    check({tag, "_done_valid"}, done_valid, 0);
    check({tag, "_done_rdata"}, done_rdata, 0);
    check({tag, "_done_err"}, done_err, 0);
  endtask

  // Raise a store-word request, optionally let it reach WAIT, then pull reset
  // in the middle of the cycle.
  task automatic reset_mid_access(input logic to_wait, input string tag);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_bits  = 3'b010;
    req_addr  = 32'h0000_0100;
    req_wdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_in_req"}, mem_req_valid, 1);
    if (to_wait) begin
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      check({tag, "_in_wait"}, mem_req_valid, 0);
    end
    #2;
    rst_n = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hFFFF_FFFF;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check({tag, "_after_done"}, done_valid, 0);
    check({tag, "_after_ready"}, req_ready, 1);
    mem_rsp_valid = 1'b0;
  endtask

  // ---------------------------------------------------------- vector table
  typedef struct {
    logic        wr;
    logic [2:0]  bits;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          rdly;
    int          sdly;
    logic [3:0]  e_wmask;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[10];

  logic        r_wr;
  logic [2:0]  r_bits;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  int          r_rdly;
  int          r_sdly;
  logic        r_align;
  logic        r_err;
  logic [31:0] r_exp;

  // ------------------------------------------------------------- main test
  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_wr        = 1'b0;
    req_bits      = 3'b000;
    req_addr      = 32'h0;
    req_wdata     = 32'h0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;

    //            wr  bits    addr          wdata         rdata         rd sd wmask    wdata         rdata         err
    vecs[0] = '{1'b0, 3'b010, 32'h80000004, 32'h00000000, 32'hDEADBEEF, 0, 0, 4'b0000, 32'h00000000, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b0, 3'b000, 32'h80000003, 32'h00000000, 32'h80FF7F01, 0, 0, 4'b0000, 32'h00000000, 32'hFFFFFF80, 1'b0};
    vecs[2] = '{1'b0, 3'b100, 32'h80000003, 32'h00000000, 32'h80FF7F01, 0, 0, 4'b0000, 32'h00000000, 32'h00000080, 1'b0};
    vecs[3] = '{1'b0, 3'b101, 32'h80000002, 32'h00000000, 32'h80FF7F01, 0, 0, 4'b0000, 32'h00000000, 32'h000080FF, 1'b0};
    vecs[4] = '{1'b1, 3'b001, 32'h80000002, 32'h1234ABCD, 32'h55555555, 0, 0, 4'b1100, 32'hABCDABCD, 32'h00000000, 1'b0};
    vecs[5] = '{1'b0, 3'b010, 32'h00000010, 32'h00000000, 32'h0BADF00D, 5, 3, 4'b0000, 32'h00000000, 32'h0BADF00D, 1'b0};
    vecs[6] = '{1'b0, 3'b010, 32'h00000020, 32'h00000000, 32'h11111111, 0, 10, 4'b0000, 32'h00000000, 32'h00000000, 1'b1};
    vecs[7] = '{1'b1, 3'b000, 32'h00000001, 32'h000000A5, 32'h00000000, 1, 1, 4'b0010, 32'hA5A5A5A5, 32'h00000000, 1'b0};
    vecs[8] = '{1'b1, 3'b010, 32'h00000040, 32'hCAFEF00D, 32'h00000000, 2, 0, 4'b1111, 32'hCAFEF00D, 32'h00000000, 1'b0};
    vecs[9] = '{1'b0, 3'b001, 32'h00000006, 32'h00000000, 32'h80017FFF, 0, 3, 4'b0000, 32'h00000000, 32'hFFFF8001, 1'b0};

    // Reset state while reset is held
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // A response while idle must not produce a completion
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    check("idle_rsp_done", done_valid, 0);
    check("idle_rsp_ready", req_ready, 1);

    // Directed table
    for (int k = 0; k < 10; k++) begin
      run_access(vecs[k].wr, vecs[k].bits, vecs[k].addr, vecs[k].wdata, vecs[k].rdata,
                 vecs[k].rdly, vecs[k].sdly, vecs[k].e_wmask, vecs[k].e_wdata,
                 vecs[k].e_rdata, vecs[k].e_err, 1'b0);
    end

    // Word load at offset 2: an error with alignment checking, else a plain word
    r_align = m_align_err(1'b0, 3'b010, 32'h8000_0002);
`ifdef LSU_ALIGN_CHECK_EN
    run_access(1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h2468_ACE0, 0, 0,
               4'h0, 32'h0, 32'h0, 1'b1, 1'b1);
`else
    run_access(1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h2468_ACE0, 0, 0,
               4'h0, 32'h0, 32'h2468_ACE0, 1'b0, r_align);
`endif

    // Reset abandoning an access in REQ and in WAIT
    reset_mid_access(1'b0, "rst_req");
    reset_mid_access(1'b1, "rst_wait");

    // Randomised accesses checked against the model
    for (int n = 0; n < 150; n++) begin
      r_wr    = 1'($urandom_range(0, 1));
      r_bits  = 3'($urandom_range(0, 7));
      r_addr  = $urandom;
      r_wdata = $urandom;
      r_rdata = $urandom;
      r_rdly  = $urandom_range(0, 3);
      r_sdly  = $urandom_range(0, 5);
      r_align = m_align_err(r_wr, r_bits, r_addr);
      r_err   = r_align || (r_sdly >= TO);
      r_exp   = (r_err || r_wr) ? 32'h0 : m_load(r_bits, r_addr, r_rdata);
      run_access(r_wr, r_bits, r_addr, r_wdata, r_rdata, r_rdly, r_sdly,
                 m_wmask(r_wr, r_bits, r_addr), m_wdata(r_bits, r_wdata),
                 r_exp, r_err, r_align);
    end

    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit that executes the memory access requested by the instruction decoder's Mem_wr / Mem_bits / ALU-address outputs.
- Drives a single-outstanding valid/ready request bus to data memory.
- Returns write-back data for loads (byte-lane extracted, sign/zero extended) and completion for stores.
- Sits between execute and write-back; the core stalls while req_ready is low.

Parameters:
RSP_TIMEOUT, 255, max cycles in WAIT without mem_rsp_valid before error completion; 0 disables the timeout.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  core presents an access
req_ready  output  1  LSU idle, can accept
req_wr  input  1  1 store, 0 load (decoder Mem_wr)
req_bits  input  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_addr  input  32  byte address (ALU result)
req_wdata  input  32  store data (rs2)
mem_req_valid  output  1  request to memory
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  32  {req_addr[31:2],2'b00}
mem_req_wen  output  1  write enable
mem_req_wmask  output  4  byte strobes
mem_req_wdata  output  32  lane-replicated store data
mem_rsp_valid  input  1  response/ack from memory
mem_rsp_rdata  input  32  read word
done_valid  output  1  one-cycle completion pulse
done_rdata  output  32  formatted load data (0 for stores)
done_err  output  1  access failed (misaligned/illegal/timeout)

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1; all other outputs 0; timeout counter 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, capture wr/bits/addr/wdata, go to REQ (or DONE with err, see Optional Feature).
- REQ: mem_req_valid=1, address/wen/wmask/wdata stable. On mem_req_ready, go to WAIT.
- WAIT: mem_rsp_valid is sampled only here. On mem_rsp_valid, register formatted data and go to DONE. Counter increments each WAIT cycle; when it reaches RSP_TIMEOUT (nonzero) with no response, go to DONE with err=1.
- DONE: done_valid=1 for exactly one cycle, then return to IDLE.
- Responses arriving in IDLE/REQ/DONE are ignored, including late responses after a timeout.
- Minimum latency:
  - Accept at edge 0.
  - mem_req_valid high in cycle 1 (ready same cycle).
  - Response in cycle 2.
  - done_valid in cycle 3.
  - Next request accepted in cycle 4.
- Lane offset off=req_addr[1:0]. Size from bits[1:0]: 00 byte, 01 half, 10 word.
- wmask: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
- wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Loads: wen=0, wmask=0. sh=rdata>>(8*off).
  - 000: sign-extend sh[7:0]; 100: zero-extend sh[7:0].
  - 001: sign-extend sh[15:0]; 101: zero-extend sh[15:0].
  - 010: rdata.
- Stores: done_rdata=0.
- done_rdata/done_err hold their values only during DONE and are 0 otherwise.
- Reset during REQ/WAIT abandons the access; mem_req_valid drops asynchronously.

Optional Feature:
- Macro LSU_ALIGN_CHECK_EN.
- Defined: the following are errors, and the LSU issues no memory request and goes from IDLE directly to DONE with done_err=1, done_rdata=0:
  - half with off[0]=1;
  - word with off!=0;
  - bits 011/110/111;
  - store with bits 100/101.
- Undefined: done_err is driven only by the timeout. Half uses off&2 and word uses off=0 (low address bits ignored). Bits 011/110/111 are treated as word. Store 100/101 is treated as 000/001.

Test Plan:
- Load word addr 0x80000004, rdata 0xDEADBEEF, mem_req_ready and rsp immediate -> mem_req_addr 0x80000004, done_valid in cycle 3, done_rdata 0xDEADBEEF, err 0.
- Load byte (000) addr 0x...3, rdata 0x80FF7F01 -> 0xFFFFFF80; same with bu (100) -> 0x00000080; hu at off 2 -> 0x000080FF.
- Store half addr 0x...2, wdata 0x1234ABCD -> wmask 4'b1100, mem_req_wdata 0xABCDABCD, done_rdata 0.
- mem_req_ready low 5 cycles, then rsp delayed 3 cycles -> request fields stable throughout, req_ready low, single done pulse.
- RSP_TIMEOUT=4, no response -> done_err=1 after 4 WAIT cycles; a response injected next cycle is ignored.
- With LSU_ALIGN_CHECK_EN, load word addr 0x...2 -> no mem_req_valid, done_valid cycle 1, err 1.
- Assert rst_n low mid-WAIT -> all outputs 0 immediately, req_ready=1.
